// File: rtl/i2cmb_pkg.sv
// Shared types for the I2C multi-bus master: register map, command codes,
// completion codes and the command-issue controller states.
package i2cmb_pkg;

    typedef enum logic [1:0] {
        REG_CSR  = 2'd0,
        REG_DPR  = 2'd1,
        REG_CMDR = 2'd2,
        REG_FSMR = 2'd3
    } reg_addr_t;

    typedef enum logic [2:0] {
        CMD_WAIT     = 3'd0,
        CMD_WRITE    = 3'd1,
        CMD_READ_ACK = 3'd2,
        CMD_READ_NAK = 3'd3,
        CMD_START    = 3'd4,
        CMD_STOP     = 3'd5,
        CMD_SET_BUS  = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        RSP_DON = 2'd0,
        RSP_NAK = 2'd1,
        RSP_AL  = 2'd2,
        RSP_ERR = 2'd3
    } rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } ctrl_state_t;

    localparam logic [7:0] CMDR_RESET = 8'h80;

    // CMDR status nibble is {DON,NAK,AL,ERR}; exactly one bit set per completion.
    function automatic logic [3:0] rsp_to_status(input rsp_t rsp);
        logic [3:0] s;
        s = 4'b0000;
        case (rsp)
            RSP_DON: s = 4'b1000;
            RSP_NAK: s = 4'b0100;
            RSP_AL:  s = 4'b0010;
            RSP_ERR: s = 4'b0001;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/i2cmb_wb_regs_ack.sv
// Wishbone slave handshake: samples cyc&stb, inserts wait states and pulses ack.
// WB_REGS_ACK_WAIT_EN adds one extra wait state before the ack.
module wb_slave_ack (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cyc_i,
    input  logic stb_i,
    input  logic we_i,
    output logic ack_o,
    output logic rd_stb,
    output logic wr_stb
);

    logic req;
    logic fire;

    assign req = cyc_i & stb_i;

`ifdef WB_REGS_ACK_WAIT_EN
    logic wait_q;

    // wait_q marks the extra cycle between sampling and ack; register work fires in it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_q <= 1'b0;
            ack_o  <= 1'b0;
        end else begin
            wait_q <= req & ~wait_q & ~ack_o;
            ack_o  <= wait_q;
        end
    end

    assign fire = wait_q;
`else
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o <= 1'b0;
        end else begin
            ack_o <= fire;
        end
    end

    assign fire = req & ~ack_o;
`endif

    // Strobes update registers on the same edge that raises ack_o.
    assign rd_stb = fire & ~we_i;
    assign wr_stb = fire & we_i;

endmodule

// File: rtl/i2cmb_wb_regs.sv
// Wishbone register file (CSR/DPR/CMDR/FSMR) for the I2C multi-bus master.
// WB_REGS_ACK_WAIT_EN selects a two-cycle ack latency in wb_slave_ack.
module i2cmb_wb_regs
    import i2cmb_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic                  enable_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [2:0]            cmd_o,
    output logic [7:0]            tx_data_o,
    input  logic                  done_i,
    input  logic [1:0]            rsp_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  bus_busy_i,
    input  logic                  bus_cap_i,
    input  logic [7:0]            fsm_state_i
);

    logic        rd_stb;
    logic        wr_stb;
    reg_addr_t   addr;
    ctrl_state_t state_q;
    logic        csr_e_q;
    logic        csr_ie_q;
    logic [3:0]  stat_q;
    logic [2:0]  cmd_q;
    logic [7:0]  tx_q;
    logic [7:0]  rx_q;
    logic        irq_pend_q;
    logic        done_ok;
    logic [7:0]  rd_data;

    wb_slave_ack u_ack (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .ack_o  (ack_o),
        .rd_stb (rd_stb),
        .wr_stb (wr_stb)
    );

    assign addr    = reg_addr_t'(adr_i);
    assign done_ok = (state_q == ST_WAIT) && done_i;

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            REG_CSR:  rd_data = {csr_e_q, csr_ie_q, bus_busy_i, bus_cap_i, 4'b0000};
            REG_DPR:  rd_data = rx_q;
            REG_CMDR: rd_data = {stat_q, 1'b0, cmd_q};
            REG_FSMR: rd_data = fsm_state_i;
            default:  rd_data = 8'h00;
        endcase
    end

    // Later assignments win: completion beats a CMDR-read clear, and disabling
    // the core beats everything else that touches the controller state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            csr_e_q    <= 1'b0;
            csr_ie_q   <= 1'b0;
            stat_q     <= CMDR_RESET[7:4];
            cmd_q      <= CMDR_RESET[2:0];
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            irq_pend_q <= 1'b0;
        end else begin
            if (state_q == ST_ISSUE && cmd_ready_i) begin
                state_q <= ST_WAIT;
            end
            if (rd_stb && addr == REG_CMDR) begin
                irq_pend_q <= 1'b0;
            end
            if (done_ok) begin
                state_q    <= ST_IDLE;
                stat_q     <= rsp_to_status(rsp_t'(rsp_i));
                rx_q       <= rx_data_i;
                irq_pend_q <= 1'b1;
            end
            if (wr_stb) begin
                case (addr)
                    REG_CSR: begin
                        csr_e_q  <= dat_i[7];
                        csr_ie_q <= dat_i[6];
                        if (csr_e_q && !dat_i[7]) begin
                            state_q    <= ST_IDLE;
                            irq_pend_q <= 1'b0;
                        end
                    end
                    REG_DPR: tx_q <= dat_i[7:0];
                    REG_CMDR: begin
                        if (csr_e_q && state_q == ST_IDLE) begin
                            cmd_q   <= dat_i[2:0];
                            stat_q  <= 4'b0000;
                            state_q <= ST_ISSUE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            dat_o <= '0;
            irq_o <= 1'b0;
        end else begin
            if (rd_stb) begin
                dat_o <= rd_data;
            end
            irq_o <= csr_ie_q & irq_pend_q;
        end
    end

    assign enable_o    = csr_e_q;
    assign cmd_valid_o = (state_q == ST_ISSUE);
    assign cmd_o       = cmd_q;
    assign tx_data_o   = tx_q;

endmodule
